mem_addr_seq: RTL

Registered, parametrised memory-address source for the multicycle CPU datapath; successor to the combinational memory-address mux. It selects the memory address from NUM_SRC datapath channels (PC, ALUOut, A, B, ...) into a held register. It also runs the exception-vector fetch sequence: it drives the vector byte address (253/254/255 by default), waits out the memory latency, captures the handler byte and returns a zero-extended handler PC with a one-cycle valid pulse.

---
 rtl/mem_addr_seq.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_addr_seq.sv
// Registered memory-address source for the multicycle datapath.
// Holds the selected datapath channel as the memory address and runs the
// exception-vector fetch: present the vector byte address, wait out the
// memory latency, capture the handler byte as a zero-extended PC.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | accepting address loads and exception requests
// WAIT    | vector address on the bus, counting down memory latency
// DONE    | handler_pc valid pulse; all requests ignored for one cycle
module mem_addr_seq #(
  parameter int WIDTH     = 32,
  parameter int NUM_SRC   = 4,
  parameter int SEL_W     = $clog2(NUM_SRC),
  parameter int VEC_BASE  = 253,
  parameter int NUM_CAUSE = 3,
  parameter int CAUSE_W   = 2,
  parameter int MEM_LAT   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         src_sel,
  input  logic                     addr_en,
  input  logic                     exc_req,
  input  logic [CAUSE_W-1:0]       exc_cause,
  input  logic [7:0]               mem_rdata,
  output logic [WIDTH-1:0]         addr_out,
  output logic                     busy,
  output logic [WIDTH-1:0]         handler_pc,
  output logic                     handler_valid,
  output logic                     cause_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [3:0]         r_cnt;
  logic [WIDTH-1:0]   r_addr;
  logic [WIDTH-1:0]   r_handler_pc;
  logic               r_busy;
  logic               r_handler_valid;
  logic               r_cause_err;

  logic [WIDTH-1:0]   w_sel_data;
  logic               w_cause_ok;
  logic [WIDTH-1:0]   w_vec_addr;

  // Channel mux; a select with no matching channel yields address 0.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_sel == SEL_W'(i)) begin
        w_sel_data = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Cause legality and vector address, both evaluated at full width.
  always_comb begin
    w_cause_ok = ({1'b0, exc_cause} < (CAUSE_W+1)'(NUM_CAUSE));
    w_vec_addr = WIDTH'(VEC_BASE) + WIDTH'(exc_cause);
  end

  // Sequencer: address register, vector fetch and status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_cnt           <= 4'd0;
      r_addr          <= '0;
      r_handler_pc    <= '0;
      r_busy          <= 1'b0;
      r_handler_valid <= 1'b0;
      r_cause_err     <= 1'b0;
    end else begin
      r_handler_valid <= 1'b0;
      r_cause_err     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (exc_req && w_cause_ok) begin
            // exception wins over a same-cycle address load
            r_addr  <= w_vec_addr;
            r_busy  <= 1'b1;
            r_cnt   <= 4'(MEM_LAT);
            r_state <= ST_WAIT;
          end else begin
            if (exc_req) begin
              r_cause_err <= 1'b1;
            end
            if (addr_en) begin
              r_addr <= w_sel_data;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_handler_pc    <= {{(WIDTH-8){1'b0}}, mem_rdata};
            r_busy          <= 1'b0;
            r_handler_valid <= 1'b1;
            r_state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_out      = r_addr;
  assign busy          = r_busy;
  assign handler_pc    = r_handler_pc;
  assign handler_valid = r_handler_valid;
  assign cause_err     = r_cause_err;

endmodule
